// File: rtl/timeslot_scheduler_pkg.sv
// Shared types and the round-robin winner function for timeslot_scheduler.
package timeslot_scheduler_pkg;

    localparam int unsigned RR_MAX_CH = 64;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // First requester after idx (mod n); idx itself is checked last, so the owner has lowest priority.
    function automatic int unsigned rr_next(input logic [RR_MAX_CH-1:0] req,
                                            input int unsigned idx,
                                            input int unsigned n);
        int unsigned win;
        int unsigned c;
        logic        found;
        win   = idx;
        found = 1'b0;
        for (int unsigned i = 1; i <= RR_MAX_CH; i++) begin
            c = (idx + i) % n;
            if ((i <= n) && !found && req[c[5:0]]) begin
                win   = c;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/timeslot_scheduler_arbiter_round_robin.sv
// Combinational round-robin arbiter: request vector plus priority pointer to one-hot winner and index.
module arbiter_round_robin
    import timeslot_scheduler_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_oh,
    output logic [IW-1:0] win,
    output logic          vld
);

    logic [RR_MAX_CH-1:0] req_ext_s;

    // Widen the request vector and pick the next owner after ptr.
    always_comb begin
        req_ext_s         = '0;
        req_ext_s[N-1:0]  = req;
        vld               = |req;
        win               = IW'(rr_next(req_ext_s, 32'(ptr), N));
        gnt_oh            = '0;
        if (vld) begin
            gnt_oh[win] = 1'b1;
        end else begin
            gnt_oh = '0;
        end
    end

endmodule

// File: rtl/timeslot_scheduler.sv
// Round-robin time-division scheduler with per-channel programmable slot length.
// Optional macro TIMESLOT_SCHEDULER_EARLY_RELEASE_EN: owner dropping req ends its slot early.
module timeslot_scheduler
    import timeslot_scheduler_pkg::*;
#(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned IW       = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    input  logic [CHANNELS-1:0]       req,
    input  logic [CHANNELS*WIDTH-1:0] len,
    output logic [CHANNELS-1:0]       gnt,
    output logic [IW-1:0]             idx,
    output logic [WIDTH-1:0]          cnt,
    output logic                      lst,
    output logic                      busy
);

    state_t               state_r, state_n;
    logic [IW-1:0]        idx_r, idx_n;
    logic [WIDTH-1:0]     cnt_r, cnt_n;
    logic [WIDTH-1:0]     len_q_r, len_n;
    logic [CHANNELS-1:0]  gnt_r, gnt_n;
    logic                 busy_r, busy_n;

    logic [CHANNELS-1:0]  arb_oh_s;
    logic [IW-1:0]        arb_win_s;
    logic                 arb_vld_s;
    logic [WIDTH-1:0]     len_a_s [CHANNELS];
    logic [WIDTH-1:0]     len_win_s;
    logic                 lst_s;
    logic                 end_s;

    arbiter_round_robin #(
        .N  (CHANNELS),
        .IW (IW)
    ) u_arb (
        .req    (req),
        .ptr    (idx_r),
        .gnt_oh (arb_oh_s),
        .win    (arb_win_s),
        .vld    (arb_vld_s)
    );

    // Unpack the flat length bus and select the arbitration winner's slot maximum.
    always_comb begin
        for (int i = 0; i < int'(CHANNELS); i++) begin
            len_a_s[i] = len[i*WIDTH +: WIDTH];
        end
        len_win_s = len_a_s[arb_win_s];
    end

    assign lst_s = busy_r & (cnt_r == len_q_r);

`ifdef TIMESLOT_SCHEDULER_EARLY_RELEASE_EN
    assign end_s = lst_s | ~req[idx_r];
`else
    assign end_s = lst_s;
`endif

    // Next-state logic: slot start, counting, zero-gap handoff and return to idle.
    always_comb begin
        state_n = state_r;
        idx_n   = idx_r;
        cnt_n   = cnt_r;
        len_n   = len_q_r;
        gnt_n   = gnt_r;
        case (state_r)
            IDLE: begin
                if (ena && arb_vld_s) begin
                    state_n = GRANT;
                    idx_n   = arb_win_s;
                    len_n   = len_win_s;
                    cnt_n   = '0;
                    gnt_n   = arb_oh_s;
                end else begin
                    gnt_n   = '0;
                end
            end
            GRANT: begin
                if (ena) begin
                    if (end_s) begin
                        if (arb_vld_s) begin
                            idx_n = arb_win_s;
                            len_n = len_win_s;
                            cnt_n = '0;
                            gnt_n = arb_oh_s;
                        end else begin
                            state_n = IDLE;
                            cnt_n   = '0;
                            gnt_n   = '0;
                        end
                    end else begin
                        cnt_n = cnt_r + WIDTH'(1);
                    end
                end else begin
                    state_n = GRANT;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                gnt_n   = '0;
            end
        endcase
        busy_n = (state_n == GRANT);
    end

    // State and output registers; reset drops any slot in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= IW'(CHANNELS - 1);
            cnt_r   <= '0;
            len_q_r <= '0;
            gnt_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            idx_r   <= idx_n;
            cnt_r   <= cnt_n;
            len_q_r <= len_n;
            gnt_r   <= gnt_n;
            busy_r  <= busy_n;
        end
    end

    assign gnt  = gnt_r;
    assign idx  = idx_r;
    assign cnt  = cnt_r;
    assign busy = busy_r;
    assign lst  = lst_s;

endmodule

// File: tb/tb_timeslot_scheduler.sv
// Directed self-checking bench for timeslot_scheduler (CHANNELS=4, WIDTH=8).
module tb_timeslot_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [3:0]  req;
    logic [31:0] len;
    logic [3:0]  gnt;
    logic [1:0]  idx;
    logic [7:0]  cnt;
    logic        lst;
    logic        busy;

    int tests_run    = 0;
    int tests_failed = 0;

    timeslot_scheduler #(.CHANNELS(4), .WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena),
        .req  (req),
        .len  (len),
        .gnt  (gnt),
        .idx  (idx),
        .cnt  (cnt),
        .lst  (lst),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ena = 1'b0;
        req = 4'b0000;
        len = 32'd0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        step();
        tests_run++;
        if ({gnt, idx, cnt, lst, busy} !== {4'b0000, 2'd3, 8'd0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset: gnt=%b idx=%0d cnt=%0d lst=%b busy=%b, want 0000/3/0/0/0", gnt, idx, cnt, lst, busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        len[7:0] = 8'd3;
        req = 4'b0001;
        ena = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (gnt !== 4'b0001 || idx !== 2'd0 || cnt !== 8'(k) || lst !== (k == 3)) begin
                tests_failed++;
                $display("FAIL single_slot[%0d]: gnt=%b idx=%0d cnt=%0d lst=%b, want 0001/0/%0d/%b", k, gnt, idx, cnt, lst, k, (k == 3));
            end
            if (k < 3) step();
        end
        step();
        tests_run++;
        if (gnt !== 4'b0001 || cnt !== 8'd0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_reslot: gnt=%b cnt=%0d busy=%b, want 0001/0/1", gnt, cnt, busy);
        end
        step(); step(); step();
        req = 4'b0000;
        step();
        tests_run++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || cnt !== 8'd0 || idx !== 2'd0 || lst !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_idle: gnt=%b busy=%b cnt=%0d idx=%0d lst=%b, want 0000/0/0/0/0", gnt, busy, cnt, idx, lst);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        do_reset();
        len = {8'd1, 8'd1, 8'd1, 8'd1};
        req = 4'b1111;
        ena = 1'b1;
        step();
        for (int c = 0; c < 10; c++) begin
            exp_gnt = 4'b0001 << ((c / 2) % 4);
            tests_run++;
            if (gnt !== exp_gnt || cnt !== 8'(c % 2) || lst !== (c % 2 == 1)) begin
                tests_failed++;
                $display("FAIL round_robin[%0d]: gnt=%b cnt=%0d lst=%b, want %b/%0d/%b", c, gnt, cnt, lst, exp_gnt, c % 2, (c % 2 == 1));
            end
            step();
        end
    endtask

    task automatic test_len_zero();
        do_reset();
        len[23:16] = 8'd0;
        len[7:0]   = 8'd5;
        req = 4'b0100;
        ena = 1'b1;
        step();
        for (int c = 0; c < 4; c++) begin
            tests_run++;
            if (gnt !== 4'b0100 || idx !== 2'd2 || cnt !== 8'd0 || lst !== 1'b1) begin
                tests_failed++;
                $display("FAIL len_zero[%0d]: gnt=%b idx=%0d cnt=%0d lst=%b, want 0100/2/0/1", c, gnt, idx, cnt, lst);
            end
            step();
        end
    endtask

    task automatic test_ena_stall();
        int     exp_cnt [5] = '{0, 1, 1, 1, 2};
        logic   ena_seq [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        len[7:0] = 8'd2;
        req = 4'b0001;
        ena = 1'b0;
        step();
        tests_run++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ena_low_idle: gnt=%b busy=%b, want 0000/0", gnt, busy);
        end
        ena = 1'b1;
        step();
        for (int c = 0; c < 5; c++) begin
            tests_run++;
            if (gnt !== 4'b0001 || cnt !== 8'(exp_cnt[c]) || lst !== (c == 4)) begin
                tests_failed++;
                $display("FAIL ena_stall[%0d]: gnt=%b cnt=%0d lst=%b, want 0001/%0d/%b", c, gnt, cnt, lst, exp_cnt[c], (c == 4));
            end
            ena = ena_seq[c];
            if (c == 4) req = 4'b0000;
            step();
        end
        tests_run++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ena_stall_end: gnt=%b busy=%b, want 0000/0", gnt, busy);
        end
    endtask

    task automatic test_reset_mid_slot();
        do_reset();
        len[15:8] = 8'd5;
        req = 4'b0010;
        ena = 1'b1;
        step();
        step();
        step();
        tests_run++;
        if (gnt !== 4'b0010 || cnt !== 8'd2) begin
            tests_failed++;
            $display("FAIL mid_slot_pre: gnt=%b cnt=%0d, want 0010/2", gnt, cnt);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (gnt !== 4'b0000 || cnt !== 8'd0 || busy !== 1'b0 || idx !== 2'd3 || lst !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_slot_reset: gnt=%b cnt=%0d busy=%b idx=%0d lst=%b, want 0000/0/0/3/0", gnt, cnt, busy, idx, lst);
        end
        req = 4'b0011;
        step();
        rst = 1'b0;
        step();
        tests_run++;
        if (gnt !== 4'b0001 || idx !== 2'd0 || cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL mid_slot_after: gnt=%b idx=%0d cnt=%0d, want 0001/0/0", gnt, idx, cnt);
        end
    endtask

    task automatic test_early_release();
        do_reset();
        len[7:0]  = 8'd7;
        len[15:8] = 8'd1;
        req = 4'b0011;
        ena = 1'b1;
        step();
        step();
        step();
        tests_run++;
        if (gnt !== 4'b0001 || cnt !== 8'd2) begin
            tests_failed++;
            $display("FAIL release_pre: gnt=%b cnt=%0d, want 0001/2", gnt, cnt);
        end
        req = 4'b0010;
        step();
`ifdef TIMESLOT_SCHEDULER_EARLY_RELEASE_EN
        tests_run++;
        if (gnt !== 4'b0010 || cnt !== 8'd0 || idx !== 2'd1) begin
            tests_failed++;
            $display("FAIL early_release: gnt=%b cnt=%0d idx=%0d, want 0010/0/1", gnt, cnt, idx);
        end
`else
        for (int k = 3; k <= 7; k++) begin
            tests_run++;
            if (gnt !== 4'b0001 || cnt !== 8'(k) || lst !== (k == 7)) begin
                tests_failed++;
                $display("FAIL hold_slot[%0d]: gnt=%b cnt=%0d lst=%b, want 0001/%0d/%b", k, gnt, cnt, lst, k, (k == 7));
            end
            step();
        end
        tests_run++;
        if (gnt !== 4'b0010 || cnt !== 8'd0 || idx !== 2'd1) begin
            tests_failed++;
            $display("FAIL hold_handoff: gnt=%b cnt=%0d idx=%0d, want 0010/0/1", gnt, cnt, idx);
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        ena = 1'b0;
        req = 4'b0000;
        len = 32'd0;
        test_reset();
        test_single();
        test_round_robin();
        test_len_zero();
        test_ena_stall();
        test_reset_mid_slot();
        test_early_release();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/timeslot_scheduler.md
# timeslot_scheduler

Time-division scheduler sharing one wrap-on-maximum slot counter between `CHANNELS` requesters. Grants one requester at a time, round-robin, for a per-channel programmable number of enabled cycles, then hands the slot to the next pending requester with no idle gap. It sits in front of any shared datapath resource that must be time-multiplexed with bounded per-channel occupancy.

## Interface
- `CHANNELS`, 4, number of requesters (≥2)
- `WIDTH`, 8, slot counter width; slot length range is 1 to 2^WIDTH cycles
- `clk`  input  1  clock
- `rst`  input  1  reset; asynchronous, active-high
- `ena`  input  1  global enable; slot counting and arbitration advance only when high
- `req`  input  CHANNELS  per-channel request, level-sensitive
- `len`  input  CHANNELS×WIDTH  per-channel slot maximum (slot length minus one)
- `gnt`  output  CHANNELS  one-hot grant, or all-zero when idle
- `idx`  output  $clog2(CHANNELS)  index of the granted channel; holds the last owner when idle
- `cnt`  output  WIDTH  cycle position within the current slot
- `lst`  output  1  last cycle of the current slot: `busy & (cnt == len_q)`
- `busy`  output  1  a slot is active

## Operation
- FSM states:
  - `IDLE`: `gnt`=0.
  - `GRANT`: `gnt` = one-hot(`idx`).
- Reset values: state `IDLE`, `gnt`=0, `idx`=CHANNELS-1, `cnt`=0, `len_q`=0, `busy`=0, `lst`=0. Reset asserted mid-slot clears everything immediately; no slot is resumed.
- Arbitration is round-robin:
  - Search starts at `idx+1` (mod CHANNELS) and the current owner has lowest priority.
  - After reset, channel 0 is first.
- `IDLE` → `GRANT` when `ena & |req`:
  - load `idx` with the winner, `len_q` ← `len[winner]`, `cnt` ← 0.
- In `GRANT` with `ena`:
  - if `!lst`, `cnt` ← `cnt+1`;
  - if `lst`, the slot ends. If `|req`, re-arbitrate and load the next owner, `len_q` and `cnt`=0 in the same edge; stay in `GRANT`. Otherwise go to `IDLE` with `cnt` ← 0.
- With `ena` low: `cnt`, `gnt`, `idx` and state all freeze; requests are ignored.
- `len_q` is sampled only at slot start. Changes to `len` mid-slot take effect at the owner's next slot.
- `len`=0 gives a one-cycle slot, so `lst` is high in the grant's first cycle.
- A sole requester re-wins consecutive slots back-to-back.
- Counter arithmetic is modulo 2^WIDTH. `cnt` never exceeds `len_q`, so no overflow path exists.

## Timing
- `gnt`, `idx`, `cnt` and `busy` are registered. `lst` is combinational from registers only.
- Latency from `req` rising (while `IDLE`, `ena` high) to `gnt` is 1 cycle.
- Handoff between slots is zero-gap: the last cycle of slot A is followed directly by the first cycle of slot B.
- A slot of owner k occupies exactly `len[k]+1` cycles with `ena` high, plus any cycles with `ena` low.

## Configuration
- `TIMESLOT_SCHEDULER_EARLY_RELEASE_EN`
  - Defined: in `GRANT` with `ena`, `req[idx]` low ends the slot at that edge, exactly as if `lst` were high (re-arbitrate or go `IDLE`). Unused cycles are forfeited.
  - Undefined: `req` of the current owner is ignored during its slot; the slot always runs to `lst`.

## Structure
- Package `timeslot_scheduler_pkg`:
  - FSM state enum (`IDLE`, `GRANT`);
  - function `rr_next(req, idx)` returning the round-robin winner index.
- One natural sub-module: `arbiter_round_robin`. It is combinational, maps `req` plus priority pointer to a one-hot winner and index, and is reused for both the `IDLE` and the slot-end arbitration.

## Test plan
- Reset, then `req`=0001 and `len[0]`=3 with `ena`=1: `gnt`=0001 after one cycle and `cnt` counts 0,1,2,3 with `lst` high at 3. Then `IDLE` if `req` has dropped; otherwise a new slot for channel 0.
- `req`=1111 and all `len`=1, held: grants cycle 0001,0010,0100,1000,0001, each lasting 2 cycles with no gap.
- `len[2]`=0 with `req`=0100: a continuous grant to channel 2, `lst` high every cycle, `cnt` stuck at 0.
- `ena` toggled 1,0,0,1 during a slot with `len`=2: `cnt` holds during the low cycles and the slot lasts 5 cycles total.
- `rst` pulsed at `cnt`=2 of a channel 1 slot: `gnt`=0 and `cnt`=0 immediately. After release, the next grant goes to channel 0 if requesting.
- With `TIMESLOT_SCHEDULER_EARLY_RELEASE_EN`, `len[0]`=7 and `req[0]` dropped at `cnt`=2 while `req[1]` is high: `gnt`=0010 on the next edge. Without the macro, channel 0 holds its grant until `cnt`=7.
